alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Sequences LEGv8 ALU operations onto an external 64-bit ALU: single-cycle ops
// pass straight through, LSL is built from repeated self-additions (acc + acc).
module alu_sequencer #(
  parameter int SHAMT_W = 6
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [10:0]        Opcode,
  input  logic [63:0]        RegA,
  input  logic [63:0]        RegB,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic [3:0]         ALUCtrl,
  output logic [63:0]        BusA,
  output logic [63:0]        BusB,
  input  logic [63:0]        BusW,
  input  logic               Zero,
  output logic               RspValid,
  input  logic               RspReady,
  output logic [63:0]        Result,
  output logic               ResultZero,
  output logic               Error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_ORR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_PASS = 4'b0111;

  function automatic logic [3:0] op_ctrl(input logic [10:0] op);
    logic [3:0] ctrl;
    ctrl = CTRL_AND;
    casez (op)
      11'b10001011000: ctrl = CTRL_ADD;
      11'b11001011000: ctrl = CTRL_SUB;
      11'b10001010000: ctrl = CTRL_AND;
      11'b10101010000: ctrl = CTRL_ORR;
      11'b10110100???: ctrl = CTRL_PASS;
      default:         ctrl = CTRL_AND;
    endcase
    return ctrl;
  endfunction

  function automatic logic op_is_lsl(input logic [10:0] op);
    return op == 11'b11010011011;
  endfunction

  function automatic logic op_supported(input logic [10:0] op);
    logic ok;
    ok = 1'b0;
    casez (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b10101010000, 11'b10110100???, 11'b11010011011: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t               state_q, state_d;
  logic [10:0]          opcode_q, opcode_d;
  logic [63:0]          a_q, a_d;      // doubles as the shift accumulator
  logic [63:0]          b_q, b_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]          result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 error_q, error_d;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    error_d  = error_q;
    ReqReady = 1'b0;
    RspValid = 1'b0;
    ALUCtrl  = CTRL_AND;
    BusA     = '0;
    BusB     = '0;

    unique case (state_q)
      IDLE: begin
        ReqReady = ~Reset;
        if (ReqValid) begin
          opcode_d = Opcode;
          a_d      = RegA;
          b_d      = RegB;
          cnt_d    = Shamt;
          if (!op_supported(Opcode)) begin
            result_d = '0;
            zero_d   = 1'b0;
            error_d  = 1'b1;
            state_d  = RESP;
          end else if (op_is_lsl(Opcode) && (Shamt != '0)) begin
            state_d = SHIFT;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        BusA = a_q;
        // LSL by zero degenerates to a pass-through of RegA on the B input.
        if (op_is_lsl(opcode_q)) begin
          ALUCtrl = CTRL_PASS;
          BusB    = a_q;
        end else begin
          ALUCtrl = op_ctrl(opcode_q);
          BusB    = b_q;
        end
        result_d = BusW;
        zero_d   = Zero;
        error_d  = 1'b0;
        state_d  = RESP;
      end

      SHIFT: begin
        ALUCtrl = CTRL_ADD;
        BusA    = a_q;
        BusB    = a_q;
        a_d     = BusW;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = BusW;
          zero_d   = Zero;
          error_d  = 1'b0;
          state_d  = RESP;
        end
      end

      RESP: begin
        RspValid = 1'b1;
        if (RspReady) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      error_q  <= error_d;
    end
  end

  assign Result     = result_q;
  assign ResultZero = zero_q;
  assign Error      = error_q;

endmodule
